// File: rtl/spi_sched_pkg.sv
// Shared types and parameter defaults for the SPI transaction scheduler.
package spi_sched_pkg;

    localparam int BITS_DEF     = 28;
    localparam int DEPTH_DEF    = 4;
    localparam int START_TO_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        STORE
    } state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by the pointers, so stale words are never presented as valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Queues SPI frames, launches them one at a time on an SPI master and
// collects the received frames into a response queue.
module spi_txn_scheduler
    import spi_sched_pkg::*;
#(
    parameter int BITS     = BITS_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int START_TO = START_TO_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    input  logic [BITS-1:0] cmd_data,
    output logic            cmd_ready,
    output logic            rsp_valid,
    output logic [BITS-1:0] rsp_data,
    input  logic            rsp_ready,
    output logic [BITS-1:0] m_data,
    output logic            m_send,
    input  logic            m_busy,
    input  logic [BITS-1:0] m_rdata,
    output logic            err_timeout,
    output logic [15:0]     done_cnt
);

    localparam int TW = $clog2(START_TO + 1);

    state_e          state_q, state_d;
    logic [BITS-1:0] cmd_q, cmd_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            err_q, err_d;
    logic [15:0]     done_q, done_d;

    logic [BITS-1:0] cmd_head;
    logic            cmd_full, cmd_empty, cmd_pop;
    logic            rsp_full, rsp_empty, rsp_push;

    assign cmd_ready   = !cmd_full;
    assign rsp_valid   = !rsp_empty;
    assign m_data      = cmd_q;
    assign err_timeout = err_q;
    assign done_cnt    = done_q;

    spi_sync_fifo #(.WIDTH(BITS), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i (cmd_data),
        .pop_i   (cmd_pop),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );

    spi_sync_fifo #(.WIDTH(BITS), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .wdata_i (m_rdata),
        .pop_i   (rsp_ready && rsp_valid),
        .rdata_o (rsp_data),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            to_cnt_q <= '0;
            err_q    <= 1'b0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        to_cnt_d = to_cnt_q;
        err_d    = err_q;
        done_d   = done_q;
        cmd_pop  = 1'b0;
        rsp_push = 1'b0;
        m_send   = 1'b0;
        unique case (state_q)
            // Only one transaction is ever in flight, so outside IDLE exactly
            // one response slot is reserved and a non-full FIFO is enough here.
            IDLE: begin
                if (!cmd_empty && !rsp_full && !m_busy) begin
                    cmd_pop = 1'b1;
                    cmd_d   = cmd_head;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                m_send   = 1'b1;
                to_cnt_d = TW'(1);
                state_d  = WAIT_START;
            end
            // to_cnt_q counts cycles since the send pulse, LAUNCH included.
            WAIT_START: begin
                if (m_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q >= TW'(START_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!m_busy) state_d = STORE;
            end
            STORE: begin
                rsp_push = 1'b1;
                done_d   = done_q + 16'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
